sum3_sequencer: RTL and testbench

- Controller that sequences a shared three-operand adder datapath to reduce a burst of N operands to one sum.
- Operands arrive one per cycle over a valid/ready stream and are paired in a holding register. Each adder firing computes acc + hold + operand, so two operands retire per adder cycle.
- Sits between an operand producer and a result consumer. Owns burst length counting, pairing, odd-length tail handling and the result handshake.

---
 rtl/sum3_sequencer.sv | 123 ++++++++++++
 tb/tb_sum3_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sum3_sequencer.sv
// Burst reducer: pairs incoming operands in a holding register and fires a
// three-operand add (acc + hold + operand) every second transfer.
module sum3_sequencer #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 5,
  parameter int SUM_W   = 12,
  parameter int MAX_LEN = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [SUM_W-1:0]  out_sum_o,
  input  logic              out_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               in_ready_s;
  logic               xfer_s;

  // in_ready depends on state alone so the producer never sees a loop through in_valid.
  assign in_ready_s  = (state_q == S_FIRST) || (state_q == S_SECOND);
  assign xfer_s      = in_valid_i & in_ready_s;
  assign in_ready_o  = in_ready_s;
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign out_sum_o   = acc_q;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      hold_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and adder control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d = '0;
          if (len_i == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = (len_i > MAX_LEN_C) ? MAX_LEN_C : len_i;
            state_d = S_FIRST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FIRST: begin
        if (xfer_s) begin
          hold_d = in_data_i;
          rem_d  = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            // Odd tail: nothing to pair with, so the adder sees a zero.
            acc_d   = acc_q + SUM_W'(in_data_i);
            state_d = S_DONE;
          end else begin
            state_d = S_SECOND;
          end
        end else begin
          state_d = S_FIRST;
        end
      end
      S_SECOND: begin
        if (xfer_s) begin
          acc_d = acc_q + SUM_W'(hold_q) + SUM_W'(in_data_i);
          rem_d = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end else begin
          state_d = S_SECOND;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sum3_sequencer.sv
// Directed and randomized bursts checked against a reference sum of the
// accepted operands.
module tb_sum3_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_sum;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  sum3_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .len_i       (len),
    .busy_o      (busy),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_sum_o   (out_sum),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = 5'(n);
    tick();
    start = 1'b0;
    len   = 5'($urandom_range(0, 31));
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Idle gap cycles, then one operand offered and transferred.
  task automatic feed(input int d, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      tick();
      check("ready_in_gap", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b1;
    in_data  = 8'(d);
    check("ready_at_xfer", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Result must be present right after the last transfer and stay put under backpressure.
  task automatic finish_burst(input int exp_sum, input int hold);
    in_valid = 1'b1;
    in_data  = 8'd99;
    check("done_valid", {31'd0, out_valid}, 32'd1);
    check("done_sum", {20'd0, out_sum}, 32'(exp_sum));
    check("done_not_ready", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {20'd0, out_sum}, 32'(exp_sum));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accepted_valid", {31'd0, out_valid}, 32'd0);
    check("accepted_busy", {31'd0, busy}, 32'd0);
  endtask

  // Reference: result is the plain sum of the first min(len,16) operands.
  task automatic run_burst(input int n, input int gapmax, input int fixed_val);
    int eff;
    int exp_sum;
    int d;
    eff = (n > 16) ? 16 : n;
    exp_sum = 0;
    do_start(n);
    for (int i = 0; i < eff; i++) begin
      d = (fixed_val >= 0) ? fixed_val : int'($urandom_range(0, 255));
      exp_sum += d;
      feed(d, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    end
    finish_burst(exp_sum, int'($urandom_range(0, 3)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 5'd0; in_valid = 1'b0;
    in_data = 8'd0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {20'd0, out_sum}, 32'd0);

    // Even burst.
    do_start(4);
    feed(10, 0); feed(20, 0); feed(30, 0); feed(40, 0);
    finish_burst(100, 0);

    // Odd burst with two-cycle gaps.
    do_start(3);
    feed(255, 0); feed(255, 2); feed(255, 2);
    finish_burst(765, 1);

    // Length saturates to 16.
    run_burst(31, 0, 255);
    run_burst(16, 1, 255);

    // Zero length, backpressure, then start coinciding with acceptance.
    do_start(0);
    check("zero_valid", {31'd0, out_valid}, 32'd1);
    check("zero_sum", {20'd0, out_sum}, 32'd0);
    for (int h = 0; h < 5; h++) begin
      tick();
      check("zero_hold_valid", {31'd0, out_valid}, 32'd1);
      check("zero_hold_sum", {20'd0, out_sum}, 32'd0);
    end
    out_ready = 1'b1; start = 1'b1; len = 5'd2;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("ignored_start_idle", {31'd0, busy}, 32'd0);
    tick();
    check("ignored_start_stays", {31'd0, busy}, 32'd0);

    // Reset mid-burst discards everything.
    do_start(6);
    feed(7, 0); feed(8, 0); feed(9, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    do_start(2);
    feed(1, 0); feed(2, 0);
    finish_burst(3, 0);

    // Start while busy is ignored.
    do_start(4);
    feed(11, 0);
    start = 1'b1; len = 5'd1;
    tick();
    start = 1'b0;
    check("busy_start_ready", {31'd0, in_ready}, 32'd1);
    feed(22, 0); feed(33, 1); feed(44, 0);
    finish_burst(110, 0);

    // Randomized bursts, back to back.
    for (int b = 0; b < 30; b++) begin
      run_burst(int'($urandom_range(0, 31)), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
